instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage for the 4-bit CPU: holds a small writable program memory, a program counter and an instruction register, and presents one instruction at a time to the decoder FSM. It advances only when the decoder signals that it has finished the current instruction's FETCH/EXEC/STORE sequence. It stops on the HLT opcode.

## Interface
- `PROG_DEPTH`, default 16: program memory depth in instructions; must equal 2^`PC_W`.
- `PC_W`, default 4: program counter width.
- Instruction width is `INSTR_W` (11) from `cpu_defs.vh`, laid out as opcode[10:8], op1[7:4], op2[3:0].
- Reset: one clock; reset is synchronous and active-low.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `start`  in  1  single-cycle pulse; begins execution at PC 0. Honoured only in IDLE or HALTED.
- `prog_we`  in  1  program memory write enable.
- `prog_addr`  in  `PC_W`  program memory write address.
- `prog_data`  in  `INSTR_W`  program memory write data.
- `instr_done`  in  1  single-cycle pulse from the decoder at the end of its STORE state.
- `instr`  out  `INSTR_W`  instruction register value, fed to the decoder.
- `instr_valid`  out  1  `instr` holds an issued, non-HLT instruction.
- `pc`  out  `PC_W`  address of the instruction in or entering `instr`.
- `halted`  out  1  high while in HALTED.
- `prog_err`  out  1  one-cycle pulse when a `prog_we` arrives while running; that write is dropped.

## Operation
- States:
  - IDLE: after reset.
  - LOAD: memory read of `mem[pc]`.
  - ISSUE: instruction presented to the decoder.
  - HALTED: execution stopped.
- IDLE to LOAD on `start`; `pc` is set to 0 on the same edge.
- LOAD, on the edge ending it:
  - `ir <= mem[pc]`.
  - If the fetched opcode is HLT (3'b111), go to HALTED; otherwise go to ISSUE.
- ISSUE:
  - `instr_valid` = 1 and `instr` is stable.
  - On `instr_done`: `pc <= pc + 1` modulo `PROG_DEPTH` (15 wraps to 0), then go to LOAD.
- HALTED to LOAD on `start`, with `pc` set to 0. `instr` keeps the HLT word and `instr_valid` = 0.
- `instr` changes only on the edge leaving LOAD. It never glitches while the decoder is mid-sequence.
- Program writes are accepted only in IDLE or HALTED and take effect on the same edge.
- `prog_we` in LOAD or ISSUE: the write is ignored and `prog_err` = 1 in the next cycle.
- Ignored events:
  - `start` in LOAD or ISSUE.
  - `instr_done` outside ISSUE.
- Simultaneous `prog_we` and `start` in IDLE: both take effect. A write to address 0 is visible to the first LOAD.
- Reset is not applied to program memory. Contents survive `rst_n`.

## Timing
- Reset values, applied on the edge with `rst_n` = 0:
  - state = IDLE
  - `pc` = 0
  - `instr` = 0
  - `instr_valid` = 0
  - `halted` = 0
  - `prog_err` = 0
- Reset mid-operation: back to IDLE on that edge, and `instr_valid` is low in the next cycle.
- Startup latency: `start` in cycle k, LOAD in k+1, `instr_valid` = 1 in k+2.
- Turnaround: `instr_done` in cycle m, LOAD in m+1, next instruction valid in m+2. That is one bubble cycle, during which `instr_valid` = 0 and `instr` holds the old value.
- HLT: HALTED is entered on the edge ending LOAD, and `halted` = 1 from the next cycle.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- In `cpu_defs.vh`:
  - `INSTR_W` and the `GET_OPCODE`/`GET_OP1`/`GET_OP2` macros, shared with the decoder.
  - Opcode constants; add `OP_HLT` = 3'b111.
  - Fetch state encodings `FS_IDLE`, `FS_LOAD`, `FS_ISSUE`, `FS_HALT`.
- One sub-module, `prog_mem`: `PROG_DEPTH` x `INSTR_W` register array with synchronous write and synchronous read. The read is registered into `ir` by the parent.
- The top level holds the FSM, `pc`, the error pulse, and the write gating.

## Test plan
- Load program {ADD, SUB, HLT} at 0..2, pulse `start`, answer each valid with `instr_done` 3 cycles later:
  - `instr` shows 0..1 in order, with `instr_valid` rising 2 cycles after each done.
  - `halted` = 1 after address 2, with `pc` = 2.
- Fill all 16 words with non-HLT instructions and run 17 instructions: `pc` goes 15 then 0, and `instr` equals `mem[0]` again.
- While in ISSUE, pulse `prog_we` to address 1 with new data: `prog_err` pulses one cycle, and the later fetch of address 1 returns the old data.
- Hold `instr` in ISSUE for 10 cycles, pulsing `start` and a stray `instr_done` during LOAD: `instr` and `pc` are unchanged, with no extra advance.
- Assert `rst_n` = 0 for one cycle mid-ISSUE: next cycle shows IDLE, `pc` = 0, `instr` = 0, `instr_valid` = 0. A following `start` re-executes from address 0 with the program intact.
- From HALTED, write address 0 = HLT and pulse `start`: returns to HALTED after LOAD, with `instr_valid` never asserted.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the fetch stage: instruction layout, opcodes, fetch states.
package instr_fetch_pkg;

    localparam int unsigned INSTR_W = 11;
    localparam int unsigned OPC_W   = 3;
    localparam int unsigned OPR_W   = 4;

    typedef enum logic [OPC_W-1:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_MOV = 3'b101,
        OP_LDI = 3'b110,
        OP_HLT = 3'b111
    } opcode_e;

    // Instruction word as seen by the decoder: opcode[10:8], op1[7:4], op2[3:0].
    typedef struct packed {
        opcode_e            opcode;
        logic [OPR_W-1:0]   op1;
        logic [OPR_W-1:0]   op2;
    } instr_t;

    typedef enum logic [1:0] {
        FS_IDLE  = 2'd0,
        FS_LOAD  = 2'd1,
        FS_ISSUE = 2'd2,
        FS_HALT  = 2'd3
    } fetch_state_e;

    function automatic opcode_e get_opcode(input logic [INSTR_W-1:0] w);
        return opcode_e'(w[INSTR_W-1 -: OPC_W]);
    endfunction

    function automatic logic [OPR_W-1:0] get_op1(input logic [INSTR_W-1:0] w);
        return w[2*OPR_W-1 -: OPR_W];
    endfunction

    function automatic logic [OPR_W-1:0] get_op2(input logic [INSTR_W-1:0] w);
        return w[OPR_W-1:0];
    endfunction

endpackage

// File: rtl/instr_fetch_prog_mem.sv
// Program memory: register array, synchronous write; read word is captured by the parent's ir.
module instr_fetch_prog_mem #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 11
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata_c
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata_c = mem_q[raddr];

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC, instruction register and IDLE/LOAD/ISSUE/HALT sequencing for the decoder.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int unsigned PROG_DEPTH = 16,
    parameter int unsigned PC_W       = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               prog_we,
    input  logic [PC_W-1:0]    prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    input  logic               instr_done,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    output logic [PC_W-1:0]    pc,
    output logic               halted,
    output logic               prog_err
);

    fetch_state_e       state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               valid_q, valid_d;
    logic               halted_q, halted_d;
    logic               err_q, err_d;
    logic               mem_we_c;
    logic [INSTR_W-1:0] mem_rdata_c;

    instr_fetch_prog_mem #(
        .DEPTH  (PROG_DEPTH),
        .ADDR_W (PC_W),
        .DATA_W (INSTR_W)
    ) u_prog_mem (
        .clk     (clk),
        .we      (mem_we_c),
        .waddr   (prog_addr),
        .wdata   (prog_data),
        .raddr   (pc_q),
        .rdata_c (mem_rdata_c)
    );

    // Next state, PC/IR update, write gating and error pulse.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        err_d    = 1'b0;
        mem_we_c = 1'b0;
        case (state_q)
            FS_IDLE, FS_HALT: begin
                mem_we_c = prog_we & rst_n;
                if (start) begin
                    state_d = FS_LOAD;
                    pc_d    = '0;
                end
            end
            FS_LOAD: begin
                err_d   = prog_we;
                ir_d    = mem_rdata_c;
                state_d = (get_opcode(mem_rdata_c) == OP_HLT) ? FS_HALT : FS_ISSUE;
            end
            FS_ISSUE: begin
                err_d = prog_we;
                if (instr_done) begin
                    pc_d    = pc_q + PC_W'(1);
                    state_d = FS_LOAD;
                end
            end
            default: begin
                state_d = FS_IDLE;
            end
        endcase
        valid_d  = (state_d == FS_ISSUE);
        halted_d = (state_d == FS_HALT);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= FS_IDLE;
            pc_q     <= '0;
            ir_q     <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
            err_q    <= err_d;
        end
    end

    assign instr       = ir_q;
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign halted      = halted_q;
    assign prog_err    = err_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: behavioural model plus directed and random stimulus.
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    localparam int unsigned PC_W  = 4;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned IW    = INSTR_W;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          prog_we = 1'b0;
    logic          instr_done = 1'b0;
    logic [PC_W-1:0] prog_addr = '0;
    logic [IW-1:0] prog_data = '0;
    logic [IW-1:0] instr;
    logic          instr_valid;
    logic [PC_W-1:0] pc;
    logic          halted;
    logic          prog_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    instr_fetch #(.PROG_DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .instr_done  (instr_done),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .halted      (halted),
        .prog_err    (prog_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode of the fetch stage, current PC, held instruction, memory image.
    localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_STOP = 3;
    int            m_mode = M_IDLE;
    logic [PC_W-1:0] m_pc = '0;
    logic [IW-1:0] m_ir = '0;
    logic          m_err = 1'b0;
    logic [IW-1:0] m_mem [DEPTH];
    bit            chk_en = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_mode = M_IDLE;
            m_pc   = '0;
            m_ir   = '0;
            m_err  = 1'b0;
            chk_en = 1'b1;
        end else begin
            m_err = prog_we && (m_mode == M_LOAD || m_mode == M_RUN);
            if (prog_we && (m_mode == M_IDLE || m_mode == M_STOP))
                m_mem[prog_addr] = prog_data;
            if (m_mode == M_IDLE || m_mode == M_STOP) begin
                if (start) begin
                    m_mode = M_LOAD;
                    m_pc   = '0;
                end
            end else if (m_mode == M_LOAD) begin
                m_ir   = m_mem[m_pc];
                m_mode = (m_ir[IW-1 -: 3] == 3'b111) ? M_STOP : M_RUN;
            end else if (instr_done) begin
                m_pc   = PC_W'((int'(m_pc) + 1) % DEPTH);
                m_mode = M_LOAD;
            end
        end
    end

    // Compare DUT outputs against the model every cycle once reset has been seen.
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_valid",  32'(instr_valid), 32'(m_mode == M_RUN));
            check("model_halted", 32'(halted),      32'(m_mode == M_STOP));
            check("model_pc",     32'(pc),          32'(m_pc));
            check("model_instr",  32'(instr),       32'(m_ir));
            check("model_err",    32'(prog_err),    32'(m_err));
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic write_word(input logic [PC_W-1:0] a, input logic [IW-1:0] d, input bit with_start);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        start     = with_start;
        @(negedge clk);
        prog_we = 1'b0;
        start   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_done();
        instr_done = 1'b1;
        @(negedge clk);
        instr_done = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!instr_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(instr_valid), 32'd1);
    endtask

    task automatic wait_halted(input string tag);
        int n = 0;
        while (!halted && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(halted), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [IW-1:0] prog1 [DEPTH];
        logic [IW-1:0] fill  [DEPTH];
        logic [IW-1:0] w_add, w_sub, w_hlt, newd;
        w_add = 11'b000_0001_0010;
        w_sub = 11'b001_0011_0100;
        w_hlt = 11'b111_0000_0000;
        for (int i = 0; i < int'(DEPTH); i++) begin
            prog1[i] = {3'($urandom_range(0, 6)), 8'($urandom)};
            fill[i]  = {3'($urandom_range(0, 6)), 8'($urandom)};
        end
        prog1[0] = w_add;
        prog1[1] = w_sub;
        prog1[2] = w_hlt;

        // Reset values
        repeat (2) cyc();
        check("rst_pc",     32'(pc),          32'd0);
        check("rst_instr",  32'(instr),       32'd0);
        check("rst_valid",  32'(instr_valid), 32'd0);
        check("rst_halted", 32'(halted),      32'd0);
        check("rst_err",    32'(prog_err),    32'd0);
        rst_n = 1'b1;
        cyc();

        // ADD, SUB, HLT program with done three cycles after each valid
        for (int i = 0; i < int'(DEPTH); i++) write_word(PC_W'(i), prog1[i], 1'b0);
        pulse_start();
        check("lat_load_valid", 32'(instr_valid), 32'd0);
        cyc();
        check("lat_issue_valid", 32'(instr_valid), 32'd1);
        check("first_instr",     32'(instr),       32'(w_add));
        repeat (3) cyc();
        pulse_done();
        check("bubble_valid", 32'(instr_valid), 32'd0);
        check("bubble_instr", 32'(instr),       32'(w_add));
        cyc();
        check("second_valid", 32'(instr_valid), 32'd1);
        check("second_instr", 32'(instr),       32'(w_sub));
        check("second_pc",    32'(pc),          32'd1);
        repeat (3) cyc();
        pulse_done();
        wait_halted("halt_reached");
        check("halt_pc",    32'(pc),          32'd2);
        check("halt_instr", 32'(instr),       32'(w_hlt));
        check("halt_valid", 32'(instr_valid), 32'd0);

        // Full memory of non-HLT words, 17 instructions to see the PC wrap
        for (int i = 0; i < int'(DEPTH); i++) write_word(PC_W'(i), fill[i], 1'b0);
        pulse_start();
        for (int i = 0; i < 17; i++) begin
            wait_valid("wrap_valid");
            if (i == 15) begin
                check("wrap_pc15",    32'(pc),    32'd15);
                check("wrap_instr15", 32'(instr), 32'(fill[15]));
            end
            if (i == 16) begin
                check("wrap_pc0",    32'(pc),    32'd0);
                check("wrap_instr0", 32'(instr), 32'(fill[0]));
            end
            if (i < 16) pulse_done();
        end

        // Write while running is dropped and flagged
        newd = fill[1] ^ 11'h0FF;
        write_word(PC_W'(1), newd, 1'b0);
        check("err_pulse", 32'(prog_err), 32'd1);
        cyc();
        check("err_clear", 32'(prog_err), 32'd0);
        pulse_done();
        wait_valid("old_valid");
        check("old_pc",   32'(pc),    32'd1);
        check("old_data", 32'(instr), 32'(fill[1]));

        // Hold in ISSUE with a stray start, then stray done/start during LOAD
        for (int k = 0; k < 10; k++) begin
            start = (k == 3);
            cyc();
            check("hold_instr", 32'(instr),       32'(fill[1]));
            check("hold_pc",    32'(pc),          32'd1);
            check("hold_valid", 32'(instr_valid), 32'd1);
        end
        start = 1'b0;
        pulse_done();
        instr_done = 1'b1;
        start      = 1'b1;
        cyc();
        instr_done = 1'b0;
        start      = 1'b0;
        wait_valid("stray_valid");
        check("no_extra_advance", 32'(pc),    32'd2);
        check("stray_instr",      32'(instr), 32'(fill[2]));

        // One-cycle reset mid-ISSUE, then rerun with memory intact
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        check("mid_rst_pc",    32'(pc),          32'd0);
        check("mid_rst_instr", 32'(instr),       32'd0);
        check("mid_rst_valid", 32'(instr_valid), 32'd0);
        pulse_start();
        wait_valid("rerun_valid");
        check("rerun_instr0", 32'(instr), 32'(fill[0]));
        pulse_done();
        wait_valid("rerun_valid1");
        check("rerun_instr1", 32'(instr), 32'(fill[1]));

        // Write HLT at 0 together with start from IDLE, then again from HALTED
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        write_word(PC_W'(0), w_hlt, 1'b1);
        wait_halted("hlt0_halted");
        check("hlt0_pc",    32'(pc),    32'd0);
        check("hlt0_instr", 32'(instr), 32'(w_hlt));
        write_word(PC_W'(0), w_hlt, 1'b0);
        pulse_start();
        for (int k = 0; k < 6; k++) begin
            check("hlt_novalid", 32'(instr_valid), 32'd0);
            cyc();
        end
        check("hlt_again", 32'(halted), 32'd1);

        // Random traffic checked against the model
        for (int c = 0; c < 3000; c++) begin
            rst_n      = ($urandom_range(0, 99) != 0);
            start      = ($urandom_range(0, 15) == 0);
            instr_done = ($urandom_range(0, 3) == 0);
            prog_we    = rst_n && ($urandom_range(0, 7) == 0);
            prog_addr  = PC_W'($urandom);
            prog_data  = IW'($urandom);
            cyc();
        end
        rst_n      = 1'b1;
        start      = 1'b0;
        instr_done = 1'b0;
        prog_we    = 1'b0;
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
